// File: rtl/draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : draw_arbiter
// Brief    : Round-robin arbiter/sequencer in front of the shared box-drawing engine.
// Revision : 1.0 - initial release
// ============================================================================
module draw_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_m,
    input  logic [2:0]  iReq,
    input  logic [26:0] iX,
    input  logic [23:0] iY,
    input  logic [8:0]  iCol,
    output logic [2:0]  oGrant,
    output logic [2:0]  oDone,
    output logic        oPlotBox,
    output logic [8:0]  oStart_X,
    output logic [7:0]  oStart_Y,
    output logic [2:0]  oColour,
    input  logic        iEngine_done,
    output logic        oBusy,
    output logic        oTimeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    logic [1:0]      r_last;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_grant;
    logic [2:0]      r_done;
    logic            r_plot;
    logic            r_busy;
    logic            r_timeout;
    logic [8:0]      r_x;
    logic [7:0]      r_y;
    logic [2:0]      r_col;

    logic [1:0]      w_win;
    logic            w_done_ok;
    logic            w_expired;

    // Walk from lowest to highest priority so the nearest requester after
    // r_last is written last and wins.
    always_comb begin
        w_win = r_last;
        for (int k = 3; k >= 1; k--) begin
            if (iReq[(int'(r_last) + k) % 3]) begin
                w_win = 2'((int'(r_last) + k) % 3);
            end
        end
    end

    // A done seen while the counter is still 0 belongs to a previous draw.
    assign w_done_ok = iEngine_done && (r_cnt != '0);
    assign w_expired = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset_m) begin
        if (reset_m) begin
            r_state   <= S_IDLE;
            r_last    <= 2'd2;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_plot    <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_col     <= '0;
        end else begin
            r_grant <= '0;
            r_done  <= '0;
            r_plot  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|iReq) begin
                        r_x     <= iX[9*int'(w_win) +: 9];
                        r_y     <= iY[8*int'(w_win) +: 8];
                        r_col   <= iCol[3*int'(w_win) +: 3];
                        r_grant <= 3'b001 << w_win;
                        r_plot  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_last  <= w_win;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done_ok || w_expired) begin
                        r_done  <= 3'b001 << r_last;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        if (!w_done_ok) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oGrant   = r_grant;
    assign oDone    = r_done;
    assign oPlotBox = r_plot;
    assign oStart_X = r_x;
    assign oStart_Y = r_y;
    assign oColour  = r_col;
    assign oBusy    = r_busy;
    assign oTimeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_arbiter
// Brief    : Directed bench; u_dut uses TIMEOUT=1024, u_dut16 TIMEOUT=16 on shared inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_arbiter;

    logic        clk = 1'b0;
    logic        reset_m;
    logic [2:0]  iReq;
    logic [26:0] iX;
    logic [23:0] iY;
    logic [8:0]  iCol;
    logic        iEngine_done;

    logic [2:0]  oGrant, oDone, oColour;
    logic        oPlotBox, oBusy, oTimeout;
    logic [8:0]  oStart_X;
    logic [7:0]  oStart_Y;

    logic [2:0]  d16_grant, d16_done, d16_col;
    logic        d16_plot, d16_busy, d16_timeout;
    logic [8:0]  d16_x;
    logic [7:0]  d16_y;

    int n_checks = 0;
    int n_fail   = 0;

    draw_arbiter #(.TIMEOUT(1024)) u_dut (
        .clk(clk), .reset_m(reset_m), .iReq(iReq), .iX(iX), .iY(iY), .iCol(iCol),
        .oGrant(oGrant), .oDone(oDone), .oPlotBox(oPlotBox), .oStart_X(oStart_X),
        .oStart_Y(oStart_Y), .oColour(oColour), .iEngine_done(iEngine_done),
        .oBusy(oBusy), .oTimeout(oTimeout)
    );

    draw_arbiter #(.TIMEOUT(16)) u_dut16 (
        .clk(clk), .reset_m(reset_m), .iReq(iReq), .iX(iX), .iY(iY), .iCol(iCol),
        .oGrant(d16_grant), .oDone(d16_done), .oPlotBox(d16_plot), .oStart_X(d16_x),
        .oStart_Y(d16_y), .oColour(d16_col), .iEngine_done(iEngine_done),
        .oBusy(d16_busy), .oTimeout(d16_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_m      = 1'b1;
        iReq         = '0;
        iX           = '0;
        iY           = '0;
        iCol         = '0;
        iEngine_done = 1'b0;
        step();
        step();
        chk("reset_ctrl", {oGrant, oDone, oPlotBox, oBusy, oTimeout}, 32'h0);
        chk("reset_data", {oStart_X, oStart_Y, oColour}, 32'h0);
        reset_m = 1'b0;
        step();

        // Single request on requester 1, engine done 20 cycles after oPlotBox
        iX   = {9'd0, 9'd100, 9'd0};
        iY   = {8'd0, 8'd50, 8'd0};
        iCol = {3'd0, 3'b101, 3'd0};
        iReq = 3'b010;
        step();
        chk("t1_grant", {oGrant, oPlotBox, oBusy}, {3'b010, 1'b1, 1'b1});
        chk("t1_data", {oStart_X, oStart_Y, oColour}, {9'd100, 8'd50, 3'd5});
        iReq = '0;
        for (int i = 0; i < 19; i++) begin
            step();
            chk("t1_wait", {oGrant, oPlotBox, oDone, oBusy}, 8'h01);
        end
        iEngine_done = 1'b1;
        step();
        chk("t1_done", {oDone, oBusy}, {3'b010, 1'b0});
        iEngine_done = 1'b0;
        step();
        chk("t1_after", {oDone, oBusy}, 4'h0);
        chk("t1_hold", {oStart_X, oStart_Y, oColour}, {9'd100, 8'd50, 3'd5});

        // All three requesting continuously, engine latency 5
        reset_m = 1'b1;
        step();
        reset_m = 1'b0;
        iX   = {9'd3, 9'd2, 9'd1};
        iY   = {8'd30, 8'd20, 8'd10};
        iCol = {3'd3, 3'd2, 3'd1};
        iReq = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t2_grant", {oGrant, oPlotBox}, {3'(3'b001 << (k % 3)), 1'b1});
            chk("t2_x", 32'(oStart_X), 32'(k % 3 + 1));
            for (int j = 0; j < 4; j++) begin
                step();
                chk("t2_nogrant", {oGrant, oDone}, 6'h0);
            end
            iEngine_done = 1'b1;
            step();
            chk("t2_done", oDone, 3'b001 << (k % 3));
            iEngine_done = 1'b0;
        end
        iReq = '0;

        // Stale done held from reset
        iEngine_done = 1'b1;
        reset_m      = 1'b1;
        step();
        reset_m = 1'b0;
        iReq    = 3'b001;
        step();
        chk("t3_grant", {oGrant, oPlotBox}, {3'b001, 1'b1});
        iReq = '0;
        step();
        chk("t3_stale", {oDone, oBusy}, {3'b000, 1'b1});
        step();
        chk("t3_done", {oDone, oBusy}, {3'b001, 1'b0});
        iEngine_done = 1'b0;
        step();
        chk("t3_idle", {oDone, oBusy}, 4'h0);

        // Asynchronous reset in the middle of a draw
        iReq = 3'b010;
        step();
        chk("t4_grant", {oGrant, oStart_X}, {3'b010, 9'd2});
        iReq = '0;
        step();
        step();
        step();
        chk("t4_busy", oBusy, 1'b1);
        reset_m = 1'b1;
        #1;
        chk("t4_async", {oGrant, oDone, oPlotBox, oBusy, oTimeout, oStart_X, oStart_Y, oColour}, 32'h0);
        step();
        chk("t4_nodone", {oGrant, oDone, oBusy}, 7'h0);
        reset_m = 1'b0;
        iReq    = 3'b111;
        step();
        chk("t4_first", oGrant, 3'b001);

        // Requester 2 raises and withdraws while requester 0 is in WAIT
        iReq = 3'b100;
        step();
        step();
        iReq = '0;
        step();
        chk("t5_wait", {oBusy, oGrant}, {1'b1, 3'b000});
        iEngine_done = 1'b1;
        step();
        chk("t5_done", oDone, 3'b001);
        iEngine_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_idle", {oGrant, oBusy, oPlotBox}, 5'h0);
        end

        // Timeout on the TIMEOUT=16 instance
        reset_m = 1'b1;
        step();
        reset_m = 1'b0;
        iX   = {9'd300, 9'd2, 9'd1};
        iY   = {8'd200, 8'd20, 8'd10};
        iCol = {3'd6, 3'd2, 3'd1};
        iReq = 3'b100;
        step();
        chk("t6_grant", {d16_grant, d16_plot}, {3'b100, 1'b1});
        chk("t6_data", {d16_x, d16_y, d16_col}, {9'd300, 8'd200, 3'd6});
        iReq = '0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t6_wait", {d16_done, d16_timeout, d16_busy}, 5'h1);
        end
        step();
        chk("t6_tmo", {d16_done, d16_timeout, d16_busy}, {3'b100, 1'b1, 1'b0});
        step();
        chk("t6_sticky", {d16_done, d16_timeout}, {3'b000, 1'b1});
        iReq = 3'b001;
        step();
        chk("t6_next", {d16_grant, d16_x}, {3'b001, 9'd1});
        iReq = '0;
        step();
        step();
        iEngine_done = 1'b1;
        step();
        chk("t6_done", {d16_done, d16_timeout}, {3'b001, 1'b1});
        chk("t6_main_tmo", oTimeout, 1'b0);
        iEngine_done = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
